// File: rtl/svfloat_addsub_arb.sv
// Round-robin arbiter sharing one add/sub datapath (rhs negate + IEEE add, RNE) among N requesters.
// Optional stats outputs (issue_cnt, inflight) exist when SVFLOAT_ADDSUB_ARB_STATS_EN is defined.
module svfloat_addsub_arb #(
    parameter type float        = logic [31:0],
    parameter int  N            = 4,
    parameter int  plr_pre_add  = 0,
    parameter int  plr_post_add = 0,
    localparam int IDW          = ($clog2(N) > 0) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N-1:0]   req_sub,
    input  float           req_lhs [N],
    input  float           req_rhs [N],
    output logic           rsp_valid,
    output logic [IDW-1:0] rsp_id,
    output float           rsp_res
`ifdef SVFLOAT_ADDSUB_ARB_STATS_EN
    ,
    output logic [31:0]    issue_cnt,
    output logic [4:0]     inflight
`endif
);

    localparam int FW = $bits(float);
    localparam int EW = (FW == 64) ? 11 : ((FW == 16) ? 5 : 8);
    localparam int MW = FW - 1 - EW;
    localparam int D  = plr_pre_add + plr_post_add;

    function automatic logic is_nan(input logic [FW-1:0] x);
        return (&x[FW-2:MW]) && (|x[MW-1:0]);
    endfunction

    function automatic logic is_inf(input logic [FW-1:0] x);
        return (&x[FW-2:MW]) && !(|x[MW-1:0]);
    endfunction

    // Mantissas carry hidden bit + fraction + guard/round/sticky; subnormals use exponent 1.
    function automatic logic [FW-1:0] fadd(input logic [FW-1:0] x, input logic [FW-1:0] y);
        logic [FW-1:0]   a, b;
        logic [EW-1:0]   ea, eb, ef;
        logic [MW+3:0]   ma, mb, mask;
        logic [MW+4:0]   s;
        logic [EW+1:0]   e;
        logic [FW-2:0]   mag;
        logic            sticky, rnd;
        int unsigned     d, lz, sh;
        if (is_nan(x) || is_nan(y) || (is_inf(x) && is_inf(y) && (x[FW-1] != y[FW-1])))
            return {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
        if (is_inf(x)) return x;
        if (is_inf(y)) return y;
        if (x[FW-2:0] < y[FW-2:0]) begin
            a = y; b = x;
        end else begin
            a = x; b = y;
        end
        ea = a[FW-2:MW];
        eb = b[FW-2:MW];
        ma = {ea != '0, a[MW-1:0], 3'b000};
        mb = {eb != '0, b[MW-1:0], 3'b000};
        d = ((ea == '0) ? 32'd1 : 32'(ea)) - ((eb == '0) ? 32'd1 : 32'(eb));
        mask = ~({(MW+4){1'b1}} << d);
        sticky = |(mb & mask);
        mb = mb >> d;
        mb[0] = mb[0] | sticky;
        if (a[FW-1] == b[FW-1]) s = {1'b0, ma} + {1'b0, mb};
        else                    s = {1'b0, ma} - {1'b0, mb};
        if (s == '0) return {a[FW-1] & b[FW-1], {(FW-1){1'b0}}};
        e = (ea == '0) ? (EW+2)'(1) : {2'b00, ea};
        if (s[MW+4]) begin
            sticky = s[0];
            s = s >> 1;
            s[0] = s[0] | sticky;
            e = e + 1'b1;
        end else begin
            lz = 0;
            for (int unsigned i = 0; i < MW + 4; i++)
                if (s[i]) lz = MW + 3 - i;
            sh = ((32'(e) - 1) < lz) ? (32'(e) - 1) : lz;
            s = s << sh;
            e = e - (EW+2)'(sh);
        end
        if (e >= (EW+2)'((1 << EW) - 1)) return {a[FW-1], {EW{1'b1}}, {MW{1'b0}}};
        ef = s[MW+3] ? e[EW-1:0] : '0;
        rnd = s[2] & (s[1] | s[0] | s[3]);
        // Rounding carry ripples into the exponent, covering subnormal->normal and overflow->inf.
        mag = {ef, s[MW+2:3]} + (FW-1)'(rnd);
        return {a[FW-1], mag};
    endfunction

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d, gnt_id;
    logic           gnt_any;
    logic           vld_q, vld_d, sub_q, sub_d;
    logic [IDW-1:0] id_q, id_d;
    logic [FW-1:0]  lhs_q, lhs_d, rhs_q, rhs_d;
    logic [FW-1:0]  opa_d, opb_d, add_a, add_b, add_res;

    always_comb begin
        int unsigned idx;
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx[IDW-1:0];
            end
        end
        if (!enable || !rst_n) gnt_any = 1'b0;
        req_ready = gnt_any ? (N'(1) << gnt_id) : '0;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        vld_d    = gnt_any;
        id_d     = id_q;
        lhs_d    = lhs_q;
        rhs_d    = rhs_q;
        sub_d    = sub_q;
        if (gnt_any) begin
            rr_ptr_d = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
            id_d     = gnt_id;
            lhs_d    = req_lhs[gnt_id];
            rhs_d    = req_rhs[gnt_id];
            sub_d    = req_sub[gnt_id];
        end
        opa_d = lhs_q;
        opb_d = (sub_q && !is_nan(rhs_q)) ? {~rhs_q[FW-1], rhs_q[FW-2:0]} : rhs_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            vld_q    <= 1'b0;
            id_q     <= '0;
            lhs_q    <= '0;
            rhs_q    <= '0;
            sub_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            vld_q    <= vld_d;
            id_q     <= id_d;
            lhs_q    <= lhs_d;
            rhs_q    <= rhs_d;
            sub_q    <= sub_d;
        end
    end

    generate
        if (plr_pre_add != 0) begin : g_pre
            logic [FW-1:0] a_q, b_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= opa_d;
                    b_q <= opb_d;
                end
            end
            assign add_a = a_q;
            assign add_b = b_q;
        end else begin : g_nopre
            assign add_a = opa_d;
            assign add_b = opb_d;
        end

        if (plr_post_add != 0) begin : g_post
            logic [FW-1:0] res_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) res_q <= '0;
                else        res_q <= fadd(add_a, add_b);
            end
            assign add_res = res_q;
        end else begin : g_nopost
            assign add_res = fadd(add_a, add_b);
        end

        if (D == 0) begin : g_notag
            assign rsp_valid = vld_q;
            assign rsp_id    = id_q;
        end else begin : g_tag
            logic [D-1:0]   tv_q, tv_d;
            logic [IDW-1:0] tid_q [D];
            logic [IDW-1:0] tid_d [D];
            always_comb begin
                tv_d[0]  = vld_q;
                tid_d[0] = id_q;
                for (int unsigned i = 1; i < D; i++) begin
                    tv_d[i]  = tv_q[i-1];
                    tid_d[i] = tid_q[i-1];
                end
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tv_q <= '0;
                    for (int unsigned i = 0; i < D; i++) tid_q[i] <= '0;
                end else begin
                    tv_q <= tv_d;
                    for (int unsigned i = 0; i < D; i++) tid_q[i] <= tid_d[i];
                end
            end
            assign rsp_valid = tv_q[D-1];
            assign rsp_id    = tid_q[D-1];
        end
    endgenerate

    assign rsp_res = float'(add_res);

`ifdef SVFLOAT_ADDSUB_ARB_STATS_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [4:0]  inflight_q, inflight_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q + 32'(gnt_any);
        inflight_d  = inflight_q + 5'(gnt_any) - 5'(rsp_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            inflight_q  <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            inflight_q  <= inflight_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign inflight  = inflight_q;
`endif

endmodule

// File: tb/tb_svfloat_addsub_arb.sv
// Directed bench for svfloat_addsub_arb: float32, N=4, one pre- and one post-add register (L=3).
module tb_svfloat_addsub_arb;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [N-1:0] req_valid, req_ready, req_sub;
    logic [31:0] req_lhs [N];
    logic [31:0] req_rhs [N];
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_res;
`ifdef SVFLOAT_ADDSUB_ARB_STATS_EN
    logic [31:0] issue_cnt;
    logic [4:0]  inflight;
    logic [31:0] cnt_snap;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    svfloat_addsub_arb #(.N(4), .plr_pre_add(1), .plr_post_add(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
        .req_lhs(req_lhs), .req_rhs(req_rhs),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_res(rsp_res)
`ifdef SVFLOAT_ADDSUB_ARB_STATS_EN
        , .issue_cnt(issue_cnt), .inflight(inflight)
`endif
    );

    typedef struct {
        int          r;
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic        sub;
        logic [31:0] res;
        logic        nan;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic f_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    // Single op from one requester; expects rsp exactly 3 cycles after the accept cycle.
    task automatic run_vec(input vec_t v);
        int n;
        req_valid = '0;
        req_valid[v.r] = 1'b1;
        req_lhs[v.r] = v.lhs;
        req_rhs[v.r] = v.rhs;
        req_sub[v.r] = v.sub;
        n = 0;
        @(negedge clk);
        while (!req_ready[v.r] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("vec_grant", 32'(req_ready), 32'(N'(1) << v.r));
        step();
        req_valid = '0;
        @(negedge clk); chk("vec_lat1", 32'(rsp_valid), 32'd0);
        @(negedge clk); chk("vec_lat2", 32'(rsp_valid), 32'd0);
        @(negedge clk); chk("vec_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("vec_rsp_id", 32'(rsp_id), 32'(v.r));
        if (v.nan) chk("vec_nan", 32'(f_is_nan(rsp_res)), 32'd1);
        else       chk("vec_res", rsp_res, v.res);
        step();
    endtask

    initial begin
        vecs[0]  = '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0};
        vecs[1]  = '{2, 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0};
        vecs[2]  = '{1, 32'h3F800000, 32'h7FC00000, 1'b1, 32'h00000000, 1'b1};
        vecs[3]  = '{3, 32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 1'b0};
        vecs[4]  = '{1, 32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0};
        vecs[5]  = '{0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0};
        vecs[6]  = '{2, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0};
        vecs[7]  = '{3, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0};
        vecs[8]  = '{0, 32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 1'b0};
        vecs[9]  = '{1, 32'h7F800000, 32'h7F800000, 1'b1, 32'h00000000, 1'b1};
        vecs[10] = '{2, 32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0};
        vecs[11] = '{3, 32'h40A00000, 32'h3F800000, 1'b1, 32'h40800000, 1'b0};
        vecs[12] = '{0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0};
        vecs[13] = '{1, 32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 1'b0};

        rst_n = 1'b0;
        enable = 1'b1;
        req_valid = '1;
        req_sub = '0;
        for (int i = 0; i < N; i++) begin
            req_lhs[i] = 32'h3F800000;
            req_rhs[i] = 32'h3F800000;
        end
        @(negedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        step();
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);
        idle(4);

        // Reset while two ops are in flight: nothing may come back, and arbitration restarts at 0.
        req_valid = 4'b0010;
        @(negedge clk); chk("rst_acc0", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b0100;
        @(negedge clk); chk("rst_acc1", 32'(req_ready), 32'b0100);
        step();
        rst_n = 1'b0;
        req_valid = '1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rst_ready_low", 32'(req_ready), 32'd0);
            chk("rst_rsp_low", 32'(rsp_valid), 32'd0);
            step();
        end
        rst_n = 1'b1;
        req_valid = '0;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (rsp_valid) seen++;
                step();
            end
            chk("rst_no_rsp", 32'(seen), 32'd0);
        end
        req_valid = 4'b1001;
        @(negedge clk); chk("rst_first_grant", 32'(req_ready), 32'b0001);
        step();
        idle(5);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Full contention from rr_ptr=0: grants 0,1,2,3,0,1,2,3, responses 3 cycles behind.
        for (int i = 0; i < N; i++) begin
            req_lhs[i] = 32'h40000000;
            req_rhs[i] = 32'h3F800000;
            req_sub[i] = i[0];
        end
        req_valid = '1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k < 8) chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            if (k >= 3) begin
                chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rr_rsp_id", 32'(rsp_id), 32'((k - 3) % 4));
                chk("rr_rsp_res", rsp_res, ((k - 3) % 2 == 1) ? 32'h3F800000 : 32'h40400000);
            end else begin
                chk("rr_rsp_idle", 32'(rsp_valid), 32'd0);
            end
            step();
            if (k == 7) req_valid = '0;
        end
        idle(3);

        // Pointer wrap: req3 alone, then req0+req3 -> 3, 0, 3.
        req_valid = 4'b1000;
        @(negedge clk); chk("wrap_g0", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'b1001;
        @(negedge clk); chk("wrap_g1", 32'(req_ready), 32'b0001);
        step();
        @(negedge clk); chk("wrap_g2", 32'(req_ready), 32'b1000);
        step();
        idle(5);

        // Back-to-back from one requester.
        req_valid = 4'b0010;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k < 3) chk("b2b_grant", 32'(req_ready), 32'b0010);
            if (k >= 3 && k < 6) begin
                chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("b2b_rsp_id", 32'(rsp_id), 32'd1);
            end
            if (k == 6) chk("b2b_rsp_end", 32'(rsp_valid), 32'd0);
            step();
            if (k == 2) req_valid = '0;
        end
        idle(3);

        // enable low blocks grants immediately while an accepted op still drains.
        req_valid = 4'b0001;
        req_lhs[0] = 32'h3F800000;
        req_rhs[0] = 32'h40000000;
        req_sub[0] = 1'b0;
        @(negedge clk); chk("en_accept", 32'(req_ready), 32'b0001);
`ifdef SVFLOAT_ADDSUB_ARB_STATS_EN
        cnt_snap = issue_cnt + 32'd1;
`endif
        step();
        enable = 1'b0;
        req_valid = '1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("en_ready_low", 32'(req_ready), 32'd0);
            chk("en_rsp_valid", 32'(rsp_valid), (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) begin
                chk("en_rsp_id", 32'(rsp_id), 32'd0);
                chk("en_rsp_res", rsp_res, 32'h40400000);
            end
            step();
        end
`ifdef SVFLOAT_ADDSUB_ARB_STATS_EN
        @(negedge clk);
        chk("stats_cnt_hold", issue_cnt, cnt_snap);
        chk("stats_inflight_zero", 32'(inflight), 32'd0);
`endif
        req_valid = '0;
        enable = 1'b1;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
